// File: rtl/approx_add_pkg.sv
// Shared defaults and FSM encodings for the approximate-adder scheduler.
package approx_add_pkg;

    localparam int unsigned WIDTH_DEF           = 16;
    localparam int unsigned APPROX_LSBS_RST_DEF = 15;
    localparam int unsigned LSBS_W              = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

endpackage

// File: rtl/rc_approx_cfg_adder.sv
// Ripple-carry adder whose low 'lsbs' bit positions use the approximate cell;
// the MSB position is always an exact full adder.
module rc_approx_cfg_adder
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [LSBS_W-1:0] lsbs,
    output logic [WIDTH:0]    sum
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_approx;

        // Approximate cell: S = ~Cin & (A | B), Cout = 1.
        assign w_approx   = (i != WIDTH - 1) && (32'(i) < 32'(lsbs));
        assign w_s[i]     = w_approx ? (~w_c[i] & (a[i] | b[i]))
                                     : (a[i] ^ b[i] ^ w_c[i]);
        assign w_c[i + 1] = w_approx ? 1'b1
                                     : ((a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i])));
    end

    assign sum = {w_c[WIDTH], w_s};

endmodule

// File: rtl/approx_add_sched.sv
// Two-requester round-robin front end sharing one configurable approximate
// adder, with a single-entry result register and valid/ready handshakes.
module approx_add_sched
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEF,
    parameter int unsigned APPROX_LSBS_RST = APPROX_LSBS_RST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic              cfg_we,
    input  logic [LSBS_W-1:0] cfg_approx_lsbs,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH:0]    res_sum,
    output logic              res_id,
    output logic              busy
);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_last_grant;
    logic [LSBS_W-1:0] r_lsbs;
    logic [WIDTH:0]    r_res_sum;
    logic              r_res_id;

    logic              w_can_accept;
    logic              w_grant_id;
    logic              w_accept;
    logic [WIDTH-1:0]  w_add_a;
    logic [WIDTH-1:0]  w_add_b;
    logic [WIDTH:0]    w_sum;

    // Handshake depends only on valids, state and res_ready (held low in reset).
    assign w_can_accept = (r_state == IDLE) || res_ready;
    assign w_grant_id   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept     = rst_n && w_can_accept && (req0_valid || req1_valid);
    assign req0_ready   = w_accept && !w_grant_id;
    assign req1_ready   = w_accept &&  w_grant_id;

    assign w_add_a = w_grant_id ? req1_a : req0_a;
    assign w_add_b = w_grant_id ? req1_b : req0_b;

    rc_approx_cfg_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .lsbs (r_lsbs),
        .sum  (w_sum)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = HOLD;
            HOLD:    if (res_ready) w_state_nxt = w_accept ? HOLD : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Config and result registers; the adder sees the pre-write lsbs value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lsbs       <= LSBS_W'(APPROX_LSBS_RST);
            r_last_grant <= 1'b1;
            r_res_sum    <= '0;
            r_res_id     <= 1'b0;
        end else begin
            if (cfg_we) r_lsbs <= cfg_approx_lsbs;
            if (w_accept) begin
                r_res_sum    <= w_sum;
                r_res_id     <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
        end
    end

    assign res_valid = (r_state == HOLD);
    assign busy      = res_valid;
    assign res_sum   = r_res_sum;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_approx_add_sched.sv
// Directed, table-driven bench for approx_add_sched with hand-computed sums.
module tb_approx_add_sched;

    typedef struct packed {
        logic        rst_n;
        logic        r0v;
        logic        r1v;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        rr;
        logic        we;
        logic [3:0]  lsbs;
        logic        e_r0;
        logic        e_r1;
        logic        e_valid;
        logic        chk_data;
        logic [16:0] e_sum;
        logic        e_id;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        cfg_we;
    logic [3:0]  cfg_approx_lsbs;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_sum;
    logic        res_id;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    approx_add_sched #(
        .WIDTH           (16),
        .APPROX_LSBS_RST (15)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req0_valid      (req0_valid),
        .req1_valid      (req1_valid),
        .req0_ready      (req0_ready),
        .req1_ready      (req1_ready),
        .req0_a          (req0_a),
        .req0_b          (req0_b),
        .req1_a          (req1_a),
        .req1_b          (req1_b),
        .cfg_we          (cfg_we),
        .cfg_approx_lsbs (cfg_approx_lsbs),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_sum         (res_sum),
        .res_id          (res_id),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic r0v, input logic r1v,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic rr, input logic we, input logic [3:0] lsbs,
                                input logic e_r0, input logic e_r1, input logic e_valid,
                                input logic chk_data, input logic [16:0] e_sum,
                                input logic e_id);
        vec_t v;
        v.rst_n = rst;   v.r0v = r0v;   v.r1v = r1v;
        v.a0 = a0;       v.b0 = b0;     v.a1 = a1;     v.b1 = b1;
        v.rr = rr;       v.we = we;     v.lsbs = lsbs;
        v.e_r0 = e_r0;   v.e_r1 = e_r1; v.e_valid = e_valid;
        v.chk_data = chk_data; v.e_sum = e_sum; v.e_id = e_id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle, check readys before the edge and result after it.
    task automatic apply(input vec_t v, input string name);
        rst_n           = v.rst_n;
        req0_valid      = v.r0v;
        req1_valid      = v.r1v;
        req0_a          = v.a0;
        req0_b          = v.b0;
        req1_a          = v.a1;
        req1_b          = v.b1;
        res_ready       = v.rr;
        cfg_we          = v.we;
        cfg_approx_lsbs = v.lsbs;
        #1;
        chk({name, ".req0_ready"}, 32'(req0_ready), 32'(v.e_r0));
        chk({name, ".req1_ready"}, 32'(req1_ready), 32'(v.e_r1));
        @(posedge clk);
        #1;
        chk({name, ".res_valid"}, 32'(res_valid), 32'(v.e_valid));
        chk({name, ".busy"},      32'(busy),      32'(v.e_valid));
        if (v.chk_data) begin
            chk({name, ".res_sum"}, 32'(res_sum), 32'(v.e_sum));
            chk({name, ".res_id"},  32'(res_id),  32'(v.e_id));
        end
    endtask

    vec_t tbl [9];

    initial begin
        //           rst r0v r1v a0       b0       a1       b1       rr we lsbs e0 e1 ev cd sum        id
        tbl[0] = mk(0,  1,  0,  16'h0001,16'h0001,16'h0000,16'h0000,1, 0, 4'd0, 0, 0, 0, 1, 17'h00000, 0);
        tbl[1] = mk(1,  1,  0,  16'h0001,16'h0001,16'h0000,16'h0000,1, 0, 4'd0, 1, 0, 1, 1, 17'h08001, 0);
        tbl[2] = mk(1,  0,  0,  16'h0000,16'h0000,16'h0000,16'h0000,1, 1, 4'd0, 0, 0, 0, 0, 17'h00000, 0);
        tbl[3] = mk(1,  0,  1,  16'h0000,16'h0000,16'hFFFF,16'h0001,1, 0, 4'd0, 0, 1, 1, 1, 17'h10000, 1);
        tbl[4] = mk(1,  0,  1,  16'h0000,16'h0000,16'h1234,16'h4321,1, 0, 4'd0, 0, 1, 1, 1, 17'h05555, 1);
        tbl[5] = mk(1,  0,  0,  16'h0000,16'h0000,16'h0000,16'h0000,1, 0, 4'd0, 0, 0, 0, 0, 17'h00000, 0);
        tbl[6] = mk(1,  0,  0,  16'h0000,16'h0000,16'h0000,16'h0000,1, 1, 4'd15,0, 0, 0, 0, 17'h00000, 0);
        tbl[7] = mk(1,  1,  0,  16'h0001,16'h0001,16'h0000,16'h0000,1, 1, 4'd0, 1, 0, 1, 1, 17'h08001, 0);
        tbl[8] = mk(1,  1,  0,  16'h0001,16'h0001,16'h0000,16'h0000,1, 0, 4'd0, 1, 0, 1, 1, 17'h00002, 0);

        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while holding a result: discard it, no valid pulse, lsbs back to 15.
        apply(mk(0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'd0,
                 0, 0, 0, 1, 17'h00000, 0), "rst_hold");
        apply(mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4'd0,
                 0, 0, 0, 1, 17'h00000, 0), "post_rst");

        // Continuous tie: grants alternate 0,1,0,1 with lsbs=15 on zero operands.
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = 1'(k & 1);
            apply(mk(1, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 4'd0,
                     !g, g, 1, 1, 17'h08000, g), $sformatf("tie%0d", k));
        end

        // Stall: both ready low, result stable despite changing operands.
        for (int k = 0; k < 3; k++) begin
            apply(mk(1, 1, 1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 0, 0, 4'd0,
                     0, 0, 1, 1, 17'h08000, 1), $sformatf("stall%0d", k));
        end
        apply(mk(1, 1, 1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1, 0, 4'd0,
                 1, 0, 1, 1, 17'h18000, 0), "release0");
        apply(mk(1, 1, 1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1, 0, 4'd0,
                 0, 1, 1, 1, 17'h08000, 1), "release1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/approx_add_sched.md
APPROX_ADD_SCHED -- requirements
Module: approx_add_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter APPROX_LSBS_RST, default 15, reset value of the approximate-LSB count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, requester 0/1 holds an operand pair.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1, requester 0/1 pair accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH, operands.
REQ-008 SHALL have port cfg_we, input, 1, load cfg_approx_lsbs.
REQ-009 SHALL have port cfg_approx_lsbs, input, 4, number of low bit positions using the approximate cell (0..15).
REQ-010 SHALL have port res_valid, output, 1, result register holds an unconsumed sum.
REQ-011 SHALL have port res_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port res_sum, output, WIDTH+1, registered sum incl. carry-out.
REQ-013 SHALL have port res_id, output, 1, requester index of res_sum.
REQ-014 SHALL have port busy, output, 1, equals res_valid.

Function
REQ-015 Datapath SHALL be one shared WIDTH-bit ripple-carry adder with carry-in 0.
- Bit positions i < lsbs (lsbs = configuration register) SHALL use the approximate cell: S = ~Z & (X | Y), Cout = 1.
- The other bit positions SHALL use exact full adders.
- Bit WIDTH-1 SHALL always be exact.
- Out[WIDTH] SHALL be the final carry.
REQ-016 FSM SHALL have states IDLE (no result held) and HOLD (result held, res_valid=1).
REQ-017 In IDLE with any reqN_valid, the block SHALL assert ready to exactly one granted requester, register sum/id on that edge, and go to HOLD; latency is acceptance edge to res_valid = 1 cycle.
REQ-018 In HOLD with res_ready=1, the block SHALL accept a new granted request in the same cycle (stay HOLD, overwrite result), else go IDLE.
REQ-019 In HOLD with res_ready=0, all reqN_ready SHALL be 0 and res_sum/res_id SHALL stay stable.
REQ-020 Arbitration SHALL be round-robin.
- When both requesters are valid, grant the one not granted last.
- When only one is valid, grant it.
- last_grant SHALL update only on acceptance.
REQ-021 Ready SHALL depend combinationally on valid, state and res_ready only; it SHALL never depend on operand values.
REQ-022 cfg_we SHALL update lsbs at the edge.
- The new value SHALL apply to requests accepted from the next cycle.
- A held result SHALL be unaffected.
- A cfg write and an acceptance in the same cycle SHALL use the old lsbs.
REQ-023 Sum SHALL be unsigned; Out width WIDTH+1, no saturation, no wrap except discarding nothing (carry kept).

Reset
REQ-024 While rst_n=0 at an edge, the block SHALL reset as follows:
- state = IDLE
- res_valid = 0
- res_sum = 0
- res_id = 0
- lsbs = APPROX_LSBS_RST
- last_grant = 1, so requester 0 wins the first tie
REQ-025 Reset during HOLD SHALL discard the held result with no res_valid pulse afterward.
REQ-026 reqN_ready SHALL be 0 during reset.

Structure
REQ-027 Package approx_add_pkg SHALL hold:
- WIDTH default
- APPROX_LSBS_RST default
- state encodings IDLE=0, HOLD=1
REQ-028 The configurable adder SHALL be one sub-module rc_approx_cfg_adder (inputs a, b, lsbs; output sum WIDTH+1, purely combinational), built from per-bit cell selection.
REQ-029 The top SHALL contain only the FSM, arbiter, config register and result register.

Verification
REQ-030 Reset, lsbs=15, req0 a=0x0001 b=0x0001 -> next cycle res_valid=1, res_sum=0x08001, res_id=0.
REQ-031 cfg_we lsbs=0, then req1 a=0xFFFF b=0x0001 -> res_sum=0x10000, res_id=1; then a=0x1234 b=0x4321 -> 0x05555.
REQ-032 Both valid every cycle, res_ready=1, lsbs=15, all operands 0 -> grants alternate 0,1,0,1 starting with 0, each res_sum=0x08000, one result per cycle.
REQ-033 res_ready=0 for 3 cycles while both valid -> both ready=0, res_sum stable; on res_ready=1 the next grant follows round-robin order.
REQ-034 cfg_we lsbs=0 in the same cycle as acceptance of 0x0001+0x0001 with old lsbs=15 -> 0x08001; next acceptance of the same operands -> 0x00002.
REQ-035 rst_n=0 one cycle while in HOLD -> res_valid=0, res_sum=0, lsbs=15 after the edge; the first subsequent tie grants requester 0.
